// File: rtl/dmem_bus_arbiter.sv
// Two-master round-robin arbiter and sequencer for the shared data-memory / I/O bus.
// Each grant runs one ACC cycle on the bus, then one DONE cycle that acks the owner.
module dmem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int IO_BIT = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_we,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_we,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_datain,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dataout,
    output logic              io_sel,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    state_t state;
    logic   own;
    logic   last;

    logic              pick_valid;
    logic              pick;
    logic [ADDR_W-1:0] pick_addr;
    logic [DATA_W-1:0] pick_wdata;
    logic              pick_we;

    // In DONE only the master that was not just acked may be granted.
    always_comb begin
        pick_valid = 1'b0;
        pick       = own;
        if (state == IDLE) begin
            pick_valid = m0_req | m1_req;
            pick       = (m0_req & m1_req) ? ~last : m1_req;
        end else if (state == DONE) begin
            pick       = ~own;
            pick_valid = own ? m0_req : m1_req;
        end
        pick_addr  = pick ? m1_addr  : m0_addr;
        pick_wdata = pick ? m1_wdata : m0_wdata;
        pick_we    = pick ? m1_we    : m0_we;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            own        <= 1'b0;
            last       <= 1'b1;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
            mem_addr   <= '0;
            mem_datain <= '0;
            mem_we     <= 1'b0;
            io_sel     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (pick_valid) begin
                        state      <= ACC;
                        own        <= pick;
                        mem_addr   <= pick_addr;
                        mem_datain <= pick_wdata;
                        mem_we     <= pick_we;
                        io_sel     <= pick_addr[IO_BIT];
                        busy       <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                ACC: begin
                    if (!mem_we) begin
                        if (own) m1_rdata <= mem_dataout;
                        else     m0_rdata <= mem_dataout;
                    end
                    if (own) m1_ack <= 1'b1;
                    else     m0_ack <= 1'b1;
                    last   <= own;
                    mem_we <= 1'b0;
                    io_sel <= 1'b0;
                    state  <= DONE;
                end
                default: begin
                    state  <= IDLE;
                    mem_we <= 1'b0;
                    io_sel <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Self-checking bench for dmem_bus_arbiter: directed scenarios plus a
// randomized run scored against a transaction-level arbitration model.
module tb_dmem_bus_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int IO_BIT = 7;

    logic              clock;
    logic              reset;
    logic              m0_req, m1_req;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic              m0_we, m1_we;
    logic              m0_ack, m1_ack;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_datain;
    logic              mem_we;
    logic [DATA_W-1:0] mem_dataout;
    logic              io_sel;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    bit          exp_last;
    logic [31:0] er [2];

    dmem_bus_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .IO_BIT(IO_BIT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .m0_req     (m0_req),
        .m0_addr    (m0_addr),
        .m0_wdata   (m0_wdata),
        .m0_we      (m0_we),
        .m0_ack     (m0_ack),
        .m0_rdata   (m0_rdata),
        .m1_req     (m1_req),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_we      (m1_we),
        .m1_ack     (m1_ack),
        .m1_rdata   (m1_rdata),
        .mem_addr   (mem_addr),
        .mem_datain (mem_datain),
        .mem_we     (mem_we),
        .mem_dataout(mem_dataout),
        .io_sel     (io_sel),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic drive_m(input bit m, input logic [31:0] a,
                           input logic [31:0] w, input logic we);
        if (m) begin
            m1_addr = a; m1_wdata = w; m1_we = we;
        end else begin
            m0_addr = a; m0_wdata = w; m0_we = we;
        end
    endtask

    task automatic test_reset();
        logic [31:0] a0, a1, d0, d1;
        a0 = $urandom; a1 = $urandom;
        reset = 1'b1;
        m0_req = 1'b1; m1_req = 1'b1;
        drive_m(0, a0, $urandom, 1'b0);
        drive_m(1, a1, $urandom, 1'b0);
        mem_dataout = $urandom;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({m0_ack, m1_ack, mem_we, io_sel, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {m0_ack, m1_ack, mem_we, io_sel, busy});
        end
        n_checks++;
        if ({mem_addr, mem_datain} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_bus: got %h expected 0", {mem_addr, mem_datain});
        end
        n_checks++;
        if ({m0_rdata, m1_rdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h expected 0", {m0_rdata, m1_rdata});
        end
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if (mem_addr !== a0 || io_sel !== a0[IO_BIT]) begin
            n_fail++;
            $display("FAIL reset_first_grant: got addr %h io %b expected %h %b",
                     mem_addr, io_sel, a0, a0[IO_BIT]);
        end
        n_checks++;
        if ({m0_ack, m1_ack, busy} !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_acc_ctrl: got %b expected 001", {m0_ack, m1_ack, busy});
        end
        d0 = $urandom; mem_dataout = d0;
        @(negedge clock);
        n_checks++;
        if ({m0_ack, m1_ack} !== 2'b10 || m0_rdata !== d0) begin
            n_fail++;
            $display("FAIL reset_m0_ack: got ack %b data %h expected 10 %h",
                     {m0_ack, m1_ack}, m0_rdata, d0);
        end
        m0_req = 1'b0;
        @(negedge clock);
        n_checks++;
        if (mem_addr !== a1 || {m0_ack, m1_ack, busy} !== 3'b001) begin
            n_fail++;
            $display("FAIL done_grant_m1: got addr %h ctrl %b expected %h 001",
                     mem_addr, {m0_ack, m1_ack, busy}, a1);
        end
        d1 = $urandom; mem_dataout = d1;
        @(negedge clock);
        n_checks++;
        if ({m0_ack, m1_ack} !== 2'b01 || m1_rdata !== d1) begin
            n_fail++;
            $display("FAIL reset_m1_ack: got ack %b data %h expected 01 %h",
                     {m0_ack, m1_ack}, m1_rdata, d1);
        end
        m1_req = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({m0_ack, m1_ack, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_idle: got %b expected 000", {m0_ack, m1_ack, busy});
        end
        er[0] = d0; er[1] = d1; exp_last = 1'b1;
    endtask

    task automatic test_single_read();
        drive_m(0, 32'h0000_0010, $urandom, 1'b0);
        m0_req = 1'b1;
        @(negedge clock);
        n_checks++;
        if (mem_addr !== 32'h10 || {io_sel, mem_we, busy, m0_ack, m1_ack} !== 5'b00100) begin
            n_fail++;
            $display("FAIL read_acc: got addr %h ctrl %b expected 10 00100",
                     mem_addr, {io_sel, mem_we, busy, m0_ack, m1_ack});
        end
        mem_dataout = 32'hDEAD_BEEF;
        @(negedge clock);
        n_checks++;
        if ({m0_ack, m1_ack} !== 2'b10 || m0_rdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL read_ack: got ack %b data %h expected 10 deadbeef",
                     {m0_ack, m1_ack}, m0_rdata);
        end
        m0_req = 1'b0;
        mem_dataout = $urandom;
        repeat (2) begin
            @(negedge clock);
            n_checks++;
            if ({m0_ack, busy} !== 2'b00 || m0_rdata !== 32'hDEAD_BEEF) begin
                n_fail++;
                $display("FAIL read_hold: got ctrl %b data %h expected 00 deadbeef",
                         {m0_ack, busy}, m0_rdata);
            end
        end
        er[0] = 32'hDEAD_BEEF; exp_last = 1'b0;
    endtask

    task automatic test_io_write();
        drive_m(1, 32'h0000_0080, 32'h0000_00A5, 1'b1);
        m1_req = 1'b1;
        mem_dataout = $urandom;
        @(negedge clock);
        n_checks++;
        if ({mem_we, io_sel, busy, m1_ack} !== 4'b1110 ||
            mem_datain !== 32'hA5 || mem_addr !== 32'h80) begin
            n_fail++;
            $display("FAIL io_write_acc: got ctrl %b addr %h data %h expected 1110 80 a5",
                     {mem_we, io_sel, busy, m1_ack}, mem_addr, mem_datain);
        end
        @(negedge clock);
        n_checks++;
        if ({mem_we, io_sel, m1_ack, m0_ack} !== 4'b0010 || m1_rdata !== er[1]) begin
            n_fail++;
            $display("FAIL io_write_ack: got ctrl %b rdata %h expected 0010 %h",
                     {mem_we, io_sel, m1_ack, m0_ack}, m1_rdata, er[1]);
        end
        m1_req = 1'b0; m1_we = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({mem_we, busy, m1_ack} !== 3'b000) begin
            n_fail++;
            $display("FAIL io_write_idle: got %b expected 000", {mem_we, busy, m1_ack});
        end
        exp_last = 1'b1;
    endtask

    task automatic test_contention();
        logic [31:0] a [2];
        logic [31:0] w [2];
        logic        we [2];
        logic [31:0] d;
        bit          o;
        for (int m = 0; m < 2; m++) begin
            a[m] = $urandom; w[m] = $urandom; we[m] = 1'($urandom_range(0, 1));
            drive_m(1'(m), a[m], w[m], we[m]);
        end
        m0_req = 1'b1; m1_req = 1'b1;
        o = ~exp_last;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            n_checks++;
            if (mem_addr !== a[o] || mem_we !== we[o] || mem_datain !== w[o] ||
                {m0_ack, m1_ack, busy} !== 3'b001) begin
                n_fail++;
                $display("FAIL contention_acc[%0d]: got addr %h we %b ctrl %b expected %h %b 001",
                         i, mem_addr, mem_we, {m0_ack, m1_ack, busy}, a[o], we[o]);
            end
            d = $urandom; mem_dataout = d;
            @(negedge clock);
            if (!we[o]) er[o] = d;
            n_checks++;
            if ({m0_ack, m1_ack} !== (o ? 2'b01 : 2'b10) ||
                {m0_rdata, m1_rdata} !== {er[0], er[1]}) begin
                n_fail++;
                $display("FAIL contention_ack[%0d]: got ack %b rdata %h expected owner %0d rdata %h",
                         i, {m0_ack, m1_ack}, {m0_rdata, m1_rdata}, o, {er[0], er[1]});
            end
            if (i >= 6) begin
                if (o) m1_req = 1'b0;
                else   m0_req = 1'b0;
            end else begin
                a[o] = $urandom; w[o] = $urandom; we[o] = 1'($urandom_range(0, 1));
                drive_m(o, a[o], w[o], we[o]);
            end
            exp_last = o;
            o = ~o;
        end
        @(negedge clock);
        n_checks++;
        if ({m0_ack, m1_ack, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL contention_idle: got %b expected 000", {m0_ack, m1_ack, busy});
        end
    endtask

    task automatic test_lone_back_to_back();
        logic [31:0] a, d;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) begin
                a = $urandom; drive_m(0, a, $urandom, 1'b0); m0_req = 1'b1;
            end
            @(negedge clock);
            n_checks++;
            if (mem_addr !== a || io_sel !== a[IO_BIT] ||
                {mem_we, busy, m0_ack, m1_ack} !== 4'b0100) begin
                n_fail++;
                $display("FAIL lone_acc[%0d]: got addr %h io %b ctrl %b expected %h %b 0100",
                         i, mem_addr, io_sel, {mem_we, busy, m0_ack, m1_ack}, a, a[IO_BIT]);
            end
            d = $urandom; mem_dataout = d;
            @(negedge clock);
            n_checks++;
            if ({m0_ack, m1_ack} !== 2'b10 || m0_rdata !== d) begin
                n_fail++;
                $display("FAIL lone_ack[%0d]: got ack %b data %h expected 10 %h",
                         i, {m0_ack, m1_ack}, m0_rdata, d);
            end
            er[0] = d;
            if (i < 2) begin
                a = $urandom; drive_m(0, a, $urandom, 1'b0);
            end else begin
                m0_req = 1'b0;
            end
            @(negedge clock);
            n_checks++;
            if ({m0_ack, m1_ack, busy, mem_we, io_sel} !== 5'b0) begin
                n_fail++;
                $display("FAIL lone_gap[%0d]: got %b expected 00000",
                         i, {m0_ack, m1_ack, busy, mem_we, io_sel});
            end
        end
        exp_last = 1'b0;
    endtask

    task automatic test_reset_mid_acc();
        logic [31:0] a1, d;
        drive_m(0, $urandom, $urandom, 1'b1);
        m0_req = 1'b1;
        @(negedge clock);
        n_checks++;
        if ({mem_we, busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL midacc_pre: got %b expected 11", {mem_we, busy});
        end
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if ({mem_we, busy, io_sel} !== 3'b000 || {mem_addr, mem_datain} !== 64'h0) begin
            n_fail++;
            $display("FAIL midacc_async: got ctrl %b bus %h expected 000 0",
                     {mem_we, busy, io_sel}, {mem_addr, mem_datain});
        end
        m0_req = 1'b0; m0_we = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({m0_ack, m1_ack} !== 2'b00) begin
            n_fail++;
            $display("FAIL midacc_noack: got %b expected 00", {m0_ack, m1_ack});
        end
        reset = 1'b0;
        er[0] = '0; er[1] = '0;
        @(negedge clock);
        n_checks++;
        if ({m0_ack, m1_ack, busy} !== 3'b000 || {m0_rdata, m1_rdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL midacc_after: got ctrl %b rdata %h expected 000 0",
                     {m0_ack, m1_ack, busy}, {m0_rdata, m1_rdata});
        end
        a1 = $urandom;
        drive_m(1, a1, $urandom, 1'b0);
        m1_req = 1'b1;
        @(negedge clock);
        n_checks++;
        if (mem_addr !== a1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midacc_m1_acc: got addr %h busy %b expected %h 1", mem_addr, busy, a1);
        end
        d = $urandom; mem_dataout = d;
        @(negedge clock);
        n_checks++;
        if ({m0_ack, m1_ack} !== 2'b01 || m1_rdata !== d) begin
            n_fail++;
            $display("FAIL midacc_m1_ack: got ack %b data %h expected 01 %h",
                     {m0_ack, m1_ack}, m1_rdata, d);
        end
        m1_req = 1'b0;
        er[1] = d; exp_last = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_random();
        logic [1:0]  rq;
        logic [31:0] ad [2];
        logic [31:0] wd [2];
        logic        w  [2];
        int          gap [2];
        bit          pend, ow, win, done_m;
        int          acc_k, ack_k;
        logic [31:0] t_addr, t_wd, t_rd;
        logic        t_we;
        rq = 2'b00; pend = 1'b0; ow = 1'b0; acc_k = -1; ack_k = -1;
        t_addr = '0; t_wd = '0; t_rd = '0; t_we = 1'b0;
        for (int m = 0; m < 2; m++) begin
            gap[m] = $urandom_range(0, 3);
            ad[m] = '0; wd[m] = '0; w[m] = 1'b0;
        end
        for (int k = 0; k < 480; k++) begin
            @(negedge clock);
            if (pend && k == acc_k) begin
                n_checks++;
                if (mem_addr !== t_addr || mem_datain !== t_wd || mem_we !== t_we ||
                    io_sel !== t_addr[IO_BIT] || {busy, m0_ack, m1_ack} !== 3'b100) begin
                    n_fail++;
                    $display("FAIL rand_acc@%0d: got %h %h %b %b %b expected %h %h %b owner %0d",
                             k, mem_addr, mem_datain, mem_we, io_sel,
                             {busy, m0_ack, m1_ack}, t_addr, t_wd, t_we, ow);
                end
            end else if (pend && k == ack_k) begin
                if (!t_we) er[ow] = t_rd;
                n_checks++;
                if ({m0_ack, m1_ack} !== (ow ? 2'b01 : 2'b10) ||
                    {busy, mem_we, io_sel} !== 3'b100) begin
                    n_fail++;
                    $display("FAIL rand_ack@%0d: got ack %b ctrl %b expected owner %0d ctrl 100",
                             k, {m0_ack, m1_ack}, {busy, mem_we, io_sel}, ow);
                end
            end else begin
                n_checks++;
                if ({busy, mem_we, io_sel, m0_ack, m1_ack} !== 5'b0) begin
                    n_fail++;
                    $display("FAIL rand_idle@%0d: got %b expected 00000",
                             k, {busy, mem_we, io_sel, m0_ack, m1_ack});
                end
            end
            n_checks++;
            if ({m0_rdata, m1_rdata} !== {er[0], er[1]}) begin
                n_fail++;
                $display("FAIL rand_rdata@%0d: got %h expected %h",
                         k, {m0_rdata, m1_rdata}, {er[0], er[1]});
            end
            if (k >= 400 && !pend && rq == 2'b00) break;
            mem_dataout = $urandom;
            if (pend && k == acc_k) t_rd = mem_dataout;
            for (int m = 0; m < 2; m++) begin
                done_m = pend && k == ack_k && ow == 1'(m);
                if (rq[m]) begin
                    if (done_m) begin
                        if (k < 400 && $urandom_range(0, 1) == 1) begin
                            ad[m] = $urandom; wd[m] = $urandom;
                            w[m] = 1'($urandom_range(0, 1));
                        end else begin
                            rq[m] = 1'b0;
                            gap[m] = $urandom_range(0, 3);
                        end
                    end
                end else if (k < 400) begin
                    if (gap[m] == 0) begin
                        rq[m] = 1'b1;
                        ad[m] = $urandom; wd[m] = $urandom;
                        w[m] = 1'($urandom_range(0, 1));
                    end else begin
                        gap[m]--;
                    end
                end
            end
            m0_req = rq[0]; m1_req = rq[1];
            drive_m(0, ad[0], wd[0], w[0]);
            drive_m(1, ad[1], wd[1], w[1]);
            win = 1'b0;
            if (pend && k == ack_k) begin
                exp_last = ow;
                if (rq[~ow]) win = ~ow;
                else         pend = 1'b0;
                if (pend) begin
                    ow = win; acc_k = k + 1; ack_k = k + 2;
                    t_addr = ad[win]; t_wd = wd[win]; t_we = w[win];
                end
            end else if (!pend && rq != 2'b00) begin
                win = (rq == 2'b11) ? ~exp_last : rq[1];
                pend = 1'b1; ow = win; acc_k = k + 1; ack_k = k + 2;
                t_addr = ad[win]; t_wd = wd[win]; t_we = w[win];
            end
        end
        n_checks++;
        if (pend || rq != 2'b00) begin
            n_fail++;
            $display("FAIL rand_drain: got pend %b req %b expected 0 00", pend, rq);
        end
        m0_req = 1'b0; m1_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_io_write();
        test_contention();
        test_lone_back_to_back();
        test_reset_mid_acc();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
